// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings and the start-op decode used by
// the MDU, the D-stage controller and the hazard unit.
package mdu_pkg;

    localparam int MDU_OP_W = 4;

    localparam logic [MDU_OP_W-1:0] MDU_NONE = 4'd0;
    localparam logic [MDU_OP_W-1:0] MULT     = 4'd1;
    localparam logic [MDU_OP_W-1:0] MULTU    = 4'd2;
    localparam logic [MDU_OP_W-1:0] DIV      = 4'd3;
    localparam logic [MDU_OP_W-1:0] DIVU     = 4'd4;
    localparam logic [MDU_OP_W-1:0] MFHI     = 4'd5;
    localparam logic [MDU_OP_W-1:0] MFLO     = 4'd6;
    localparam logic [MDU_OP_W-1:0] MTHI     = 4'd7;
    localparam logic [MDU_OP_W-1:0] MTLO     = 4'd8;

    // True for the ops that occupy the unit for multiple cycles.
    function automatic logic is_mdu_start(input logic [MDU_OP_W-1:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit. Arithmetic is combinational from the
// E-stage operands; the result is parked in a shadow register and committed
// to HI/LO only after the fixed op latency, tracked by a down-counter.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [31:0]         v_rs,
    input  logic [31:0]         v_rt,
    output logic                busy,
    output logic                mdu_stall_req,
    output logic [31:0]         v_hi,
    output logic [31:0]         v_lo,
    output logic [31:0]         v_mdu_out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

    logic [0:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      sh_hi_q, sh_hi_d;
    logic [31:0]      sh_lo_q, sh_lo_d;
    logic             sh_wr_q, sh_wr_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic [31:0] res_hi, res_lo;
    logic [CNT_W-1:0] res_cnt;

    // Divisor is forced to 1 on divide-by-zero (result discarded anyway) and on
    // INT_MIN / -1, where INT_MIN / 1 already gives the wrapped quotient and a
    // zero remainder without ever evaluating the overflowing divide.
    assign div_zero = (v_rt == 32'd0);
    assign div_ovf  = (v_rs == 32'h8000_0000) && (v_rt == 32'hFFFF_FFFF);
    assign divisor  = (div_zero || div_ovf) ? 32'd1 : v_rt;

    assign prod_s = $signed({{32{v_rs[31]}}, v_rs}) * $signed({{32{v_rt[31]}}, v_rt});
    assign prod_u = {32'd0, v_rs} * {32'd0, v_rt};
    assign quo_s  = $signed(v_rs) / $signed(divisor);
    assign rem_s  = $signed(v_rs) % $signed(divisor);
    assign quo_u  = v_rs / divisor;
    assign rem_u  = v_rs % divisor;

    // Select the result, latency and write-enable for the op being issued.
    always_comb begin
        res_hi  = prod_s[63:32];
        res_lo  = prod_s[31:0];
        res_cnt = MUL_LOAD;
        case (mdu_op)
            MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            DIV: begin
                res_hi  = rem_s;
                res_lo  = quo_s;
                res_cnt = DIV_LOAD;
            end
            DIVU: begin
                res_hi  = rem_u;
                res_lo  = quo_u;
                res_cnt = DIV_LOAD;
            end
            default: ;
        endcase
    end

    // IDLE/RUN sequencing, latency countdown and HI/LO commit.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        sh_wr_d = sh_wr_q;
        if (state_q == ST_IDLE) begin
            if (is_mdu_start(mdu_op)) begin
                sh_hi_d = res_hi;
                sh_lo_d = res_lo;
                sh_wr_d = !(((mdu_op == DIV) || (mdu_op == DIVU)) && div_zero);
                cnt_d   = res_cnt;
                state_d = ST_RUN;
                busy_d  = 1'b1;
            end else if (mdu_op == MTHI) begin
                hi_d = v_rs;
            end else if (mdu_op == MTLO) begin
                lo_d = v_rs;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                if (sh_wr_q) begin
                    hi_d = sh_hi_q;
                    lo_d = sh_lo_q;
                end
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    // Register update; reset wins over everything, dropping any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_hi_q <= '0;
            sh_lo_q <= '0;
            sh_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_hi_q <= sh_hi_d;
            sh_lo_q <= sh_lo_d;
            sh_wr_q <= sh_wr_d;
        end
    end

    // Flag ops that the hazard unit should never let reach a busy MDU.
    always @(posedge clk) begin
        if (!reset && busy_q) begin
            assert (!(is_mdu_start(mdu_op) || mdu_op == MTHI || mdu_op == MTLO))
                else $warning("mdu: op %0d issued while busy, ignored", mdu_op);
        end
    end

    assign busy          = busy_q;
    assign mdu_stall_req = busy_q || is_mdu_start(mdu_op);
    assign v_hi          = hi_q;
    assign v_lo          = lo_q;
    assign v_mdu_out     = (mdu_op == MFHI) ? hi_q :
                           (mdu_op == MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit with hand-computed expected values.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic                clk;
    logic                reset;
    logic [MDU_OP_W-1:0] mdu_op;
    logic [31:0]         v_rs;
    logic [31:0]         v_rt;
    logic                busy;
    logic                mdu_stall_req;
    logic [31:0]         v_hi;
    logic [31:0]         v_lo;
    logic [31:0]         v_mdu_out;

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .clk          (clk),
        .reset        (reset),
        .mdu_op       (mdu_op),
        .v_rs         (v_rs),
        .v_rt         (v_rt),
        .busy         (busy),
        .mdu_stall_req(mdu_stall_req),
        .v_hi         (v_hi),
        .v_lo         (v_lo),
        .v_mdu_out    (v_mdu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a multi-cycle op, check the stall in the issue cycle, then check
    // busy/stall and unchanged HI/LO in each of the n busy cycles, then idle.
    task automatic run_op(input string tag, input logic [MDU_OP_W-1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] old_hi, input logic [31:0] old_lo);
        @(negedge clk);
        mdu_op = op; v_rs = a; v_rt = b;
        #1 chk({tag, " issue stall"}, 32'(mdu_stall_req), 32'd1);
        @(negedge clk);
        mdu_op = MDU_NONE; v_rs = 32'd0; v_rt = 32'd0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " stall"}, 32'(mdu_stall_req), 32'd1);
            chk({tag, " hi held"}, v_hi, old_hi);
            chk({tag, " lo held"}, v_lo, old_lo);
            @(negedge clk);
        end
        #1;
        chk({tag, " done busy"}, 32'(busy), 32'd0);
        chk({tag, " done stall"}, 32'(mdu_stall_req), 32'd0);
    endtask

    task automatic mt(input logic [MDU_OP_W-1:0] op, input logic [31:0] val);
        @(negedge clk);
        mdu_op = op; v_rs = val;
        @(negedge clk);
        mdu_op = MDU_NONE; v_rs = 32'd0;
    endtask

    initial begin
        reset = 1'b1; mdu_op = MDU_NONE; v_rs = 32'd0; v_rt = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst stall", 32'(mdu_stall_req), 32'd0);
        chk("rst hi", v_hi, 32'd0);
        chk("rst lo", v_lo, 32'd0);
        chk("rst mdu_out", v_mdu_out, 32'd0);

        // 1: MULT -2 * 3
        run_op("mult", MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'd0, 32'd0);
        chk("mult hi", v_hi, 32'hFFFF_FFFF);
        chk("mult lo", v_lo, 32'hFFFF_FFFA);

        // 2: MULTU max * max
        run_op("multu", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        chk("multu hi", v_hi, 32'hFFFF_FFFE);
        chk("multu lo", v_lo, 32'h0000_0001);

        // MULT INT_MIN * INT_MIN = 2^62
        run_op("mult min", MULT, 32'h8000_0000, 32'h8000_0000, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        chk("mult min hi", v_hi, 32'h4000_0000);
        chk("mult min lo", v_lo, 32'h0000_0000);

        // 3: DIV -7 / 2, then DIVU 7 / 2
        run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'h4000_0000, 32'h0000_0000);
        chk("div hi", v_hi, 32'hFFFF_FFFF);
        chk("div lo", v_lo, 32'hFFFF_FFFD);
        run_op("divu", DIVU, 32'd7, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        chk("divu hi", v_hi, 32'd1);
        chk("divu lo", v_lo, 32'd3);

        // 4: divide by zero leaves HI/LO, then overflow case
        mt(MTHI, 32'h11);
        mt(MTLO, 32'h22);
        #1;
        chk("mthi", v_hi, 32'h11);
        chk("mtlo", v_lo, 32'h22);
        run_op("div0", DIV, 32'd1234, 32'd0, 10, 32'h11, 32'h22);
        chk("div0 hi", v_hi, 32'h11);
        chk("div0 lo", v_lo, 32'h22);
        run_op("divu0", DIVU, 32'hFFFF_0000, 32'd0, 10, 32'h11, 32'h22);
        chk("divu0 hi", v_hi, 32'h11);
        chk("divu0 lo", v_lo, 32'h22);
        run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h11, 32'h22);
        chk("div ovf hi", v_hi, 32'd0);
        chk("div ovf lo", v_lo, 32'h8000_0000);

        // 5: MTHI then MFHI / MFLO readback
        mt(MTHI, 32'h1234);
        mdu_op = MFHI;
        #1 chk("mfhi", v_mdu_out, 32'h1234);
        chk("mfhi stall", 32'(mdu_stall_req), 32'd0);
        @(negedge clk);
        mdu_op = MFLO;
        #1 chk("mflo", v_mdu_out, 32'h8000_0000);
        @(negedge clk);
        mdu_op = MDU_NONE;

        // MULT 2*3 with a stray MTLO in busy cycle 2 (ignored, warns)
        mdu_op = MULT; v_rs = 32'd2; v_rt = 32'd3;
        @(negedge clk);
        mdu_op = MDU_NONE; v_rs = 32'd0; v_rt = 32'd0;
        @(negedge clk);
        mdu_op = MTLO; v_rs = 32'hAAAA;
        #1 chk("mtlo busy stall", 32'(mdu_stall_req), 32'd1);
        @(negedge clk);
        mdu_op = MDU_NONE; v_rs = 32'd0;
        #1 chk("mtlo busy lo", v_lo, 32'h8000_0000);
        repeat (3) @(negedge clk);
        #1;
        chk("mult23 busy", 32'(busy), 32'd0);
        chk("mult23 hi", v_hi, 32'd0);
        chk("mult23 lo", v_lo, 32'd6);

        // 6: DIV 100/7 aborted by reset in busy cycle 3
        mt(MTHI, 32'h55);
        mdu_op = DIV; v_rs = 32'd100; v_rt = 32'd7;
        @(negedge clk);
        mdu_op = MDU_NONE; v_rs = 32'd0; v_rt = 32'd0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("abort pre busy", 32'(busy), 32'd1);
        chk("abort pre hi", v_hi, 32'h55);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hi", v_hi, 32'd0);
        chk("abort lo", v_lo, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("abort hold busy", 32'(busy), 32'd0);
            chk("abort hold hi", v_hi, 32'd0);
            chk("abort hold lo", v_lo, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit. Consumes operands and the decoded MDU operation latched by the D/E pipeline register.
- Owns the architectural HI/LO registers and models fixed multi-cycle latency through a busy flag.
- Returns MFHI/MFLO read data to the E-stage result mux.
- Exports a stall request that the hazard unit uses to hold the D stage.

Parameters:
- MUL_CYCLES, 5, busy cycles for MULT/MULTU.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU.
- CNT_W, 4, latency counter width; must hold DIV_CYCLES.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mdu_op  in  4  E-stage MDU operation; MDU_NONE for bubbles and non-MDU instrs.
- v_rs  in  32  forwarded rs value, E stage.
- v_rt  in  32  forwarded rt value, E stage.
- busy  out  1  registered; high while a mult/div is in flight.
- mdu_stall_req  out  1  combinational: busy OR (mdu_op in {MULT,MULTU,DIV,DIVU}).
- v_hi  out  32  architectural HI.
- v_lo  out  32  architectural LO.
- v_mdu_out  out  32  combinational: v_hi for MFHI, v_lo for MFLO, else 0.

Behaviour:
- Reset (sync, edge with reset=1):
  - state=IDLE, busy=0, counter=0, v_hi=v_lo=0, shadow results=0.
  - Reset overrides every other input, including reset mid-operation: the pending result is discarded and never written.
- FSM: IDLE, RUN.
- IDLE, mdu_op is MULT/MULTU/DIV/DIVU at edge t:
  - latch the result into shadow hi/lo;
  - load counter with MUL_CYCLES or DIV_CYCLES;
  - state<=RUN, busy<=1.
- RUN:
  - counter decrements each edge.
  - At the edge where counter==1: v_hi/v_lo<=shadow, busy<=0, state<=IDLE.
  - Net timing: busy is high for exactly N cycles after edge t; new HI/LO are visible in the first cycle busy is 0.
- Arithmetic:
  - MULT: signed 32x32->64; HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32x32->64; HI=[63:32], LO=[31:0].
  - DIV: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (DIV or DIVU): full DIV_CYCLES busy, then HI/LO left unchanged (no write).
- MTHI/MTLO in IDLE: v_hi (MTHI) or v_lo (MTLO) <= v_rs at that edge.
- MTHI/MTLO while busy: ignored, and a simulation assertion fires. The hazard unit guarantees this never happens.
- Mult/div op while busy: ignored, and an assertion fires. The stall guarantees this never happens.
- MFHI/MFLO while busy: return the current architectural value. The hazard unit stalls these, so this is never architecturally observed.
- mdu_stall_req includes the issuing cycle, so an MDU instruction in D stalls when E is starting a mult/div.
- All arithmetic is combinational from v_rs/v_rt; only HI/LO writes are delayed.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8;
  - width constant MDU_OP_W=4;
  - an is_mdu_start() helper, also reused by the D-stage controller and the hazard unit.
- No sub-module: the FSM, counter and arithmetic fit in one module.

Test Plan:
1. Reset, then MULT v_rs=0xFFFFFFFE, v_rt=3 -> busy=1 for 5 cycles; then busy=0, v_hi=0xFFFFFFFF, v_lo=0xFFFFFFFA.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles v_hi=0xFFFFFFFE, v_lo=0x00000001; mdu_stall_req=1 in the issue cycle and all 5 busy cycles.
3. DIV 0xFFFFFFF9 / 2 -> after 10 cycles v_lo=0xFFFFFFFD, v_hi=0xFFFFFFFF; then DIVU 7/2 -> v_lo=3, v_hi=1.
4. Divide by zero and overflow:
   - MTHI 0x11, MTLO 0x22, then DIV x/0 -> busy 10 cycles; HI=0x11, LO=0x22 unchanged.
   - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
5. MTHI 0x1234 then MFHI next cycle -> v_mdu_out=0x1234. Start MULT 2x3 and issue MTLO 0xAAAA in busy cycle 2 -> assertion fires; final LO=6.
6. DIV 100/7 with reset=1 in busy cycle 3 -> next cycle busy=0, v_hi=v_lo=0, and neither changes during the following 10 cycles.
